// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared states, opcodes, fault codes and instruction field positions
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ADDR,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_ALIGN   = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT = 2'b11;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/addr_gen.sv
// addr_gen: effective address = base + sign-extended imm16, with word-misalign flag
module addr_gen (
  input  logic [31:0] i_base,
  input  logic [15:0] i_imm,
  output logic [31:0] o_sum,
  output logic        o_misalign
);

  assign o_sum      = i_base + {{16{i_imm[15]}}, i_imm};
  assign o_misalign = |o_sum[1:0];

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer between issue, register file and data memory
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_we;
  logic [7:0]  r_cnt;
  logic [1:0]  r_fault;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [15:0] w_imm;
  logic        w_is_sw;
  logic        w_legal;
  logic        w_timeout;
  logic [31:0] w_sum;
  logic        w_misalign;
  logic        w_rd_phase;

  assign w_op       = r_instr[OP_HI:OP_LO];
  assign w_rs       = r_instr[RS_HI:RS_LO];
  assign w_rt       = r_instr[RT_HI:RT_LO];
  assign w_imm      = r_instr[IMM_HI:IMM_LO];
  assign w_is_sw    = w_op == OP_SW;
  assign w_legal    = w_is_sw || w_op == OP_LW;
  assign w_timeout  = r_cnt == 8'(TIMEOUT - 1);
  assign w_rd_phase = r_state == S_DECODE || r_state == S_ADDR;

  addr_gen u_addr_gen (
    .i_base     (rf_rdata1),
    .i_imm      (w_imm),
    .o_sum      (w_sum),
    .o_misalign (w_misalign)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state: ack beats timeout in MEM; faults short-circuit to DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_DECODE : S_IDLE;
      S_DECODE: w_next = w_legal ? S_ADDR : S_DONE;
      S_ADDR:   w_next = w_misalign ? S_DONE : S_MEM;
      S_MEM:    w_next = mem_ack ? (w_is_sw ? S_DONE : S_WB) : (w_timeout ? S_DONE : S_MEM);
      S_WB:     w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // datapath: instruction latch, address/data registers, wait counter, fault code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr     <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_cnt       <= '0;
      r_fault     <= FLT_NONE;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_instr <= instruction;
        r_fault <= FLT_NONE;
      end
      if (r_state == S_DECODE && !w_legal) r_fault <= FLT_ILLEGAL;
      if (r_state == S_ADDR) begin
        r_cnt <= '0;
        if (w_misalign) begin
          r_fault <= FLT_ALIGN;
        end else begin
          r_mem_addr  <= w_sum;
          r_mem_wdata <= w_is_sw ? rf_rdata2 : '0;
          r_mem_we    <= w_is_sw;
        end
      end
      if (r_state == S_MEM) begin
        if (mem_ack)        r_rdata <= mem_rdata;
        else if (w_timeout) r_fault <= FLT_TIMEOUT;
        else                r_cnt   <= r_cnt + 8'd1;
      end
      if (r_state == S_DONE) begin
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
        r_mem_we    <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end

  assign rf_raddr1 = w_rd_phase ? w_rs : '0;
  assign rf_raddr2 = w_rd_phase ? w_rt : '0;
  assign rf_we     = r_state == S_WB && w_rt != 5'd0;
  assign rf_waddr  = r_state == S_WB ? w_rt : '0;
  assign rf_wdata  = r_state == S_WB ? r_rdata : '0;
  assign mem_req   = r_state == S_MEM;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_DONE;
  assign fault     = r_fault;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized load/store transactions against a transaction-level model
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instruction = '0;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we, mem_req, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [1:0]  fault;
  logic [31:0] rf [32];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .fault(fault)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [117:0] outs();
    return {rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata, mem_req, mem_we, mem_addr, mem_wdata, busy, done, fault};
  endfunction

  // wt: MEM cycle (1-based) on which ack is returned, 0 = never
  task automatic run(input string name, input logic [31:0] ins, input int wt, input logic [31:0] rd, input bit poke);
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] ea, a, wd, wdat;
    logic [4:0]  wa;
    logic        we;
    logic [1:0]  eflt, flt;
    bit          st, ld;
    int          ereq, edone, ewe;
    int          req, done_at, we_n, unstable, bad;
    op   = ins[31:26];
    rt   = ins[20:16];
    ea   = rf[ins[25:21]] + 32'($signed(ins[15:0]));
    st   = op == OP_SW;
    ld   = op == OP_LW;
    if (!st && !ld) begin eflt = 2'd1; ereq = 0; edone = 2; end
    else if (ea[1:0] != 2'd0) begin eflt = 2'd2; ereq = 0; edone = 3; end
    else if (wt >= 1 && wt <= TO) begin eflt = 2'd0; ereq = wt; edone = 2 + wt + (st ? 1 : 2); end
    else begin eflt = 2'd3; ereq = TO; edone = 2 + TO + 1; end
    ewe = (ld && eflt == 2'd0 && rt != 5'd0) ? 1 : 0;
    req = 0; done_at = -1; we_n = 0; unstable = 0; bad = 0;
    a = '0; wd = '0; we = 1'b0; wa = '0; wdat = '0; flt = '0;
    @(negedge clk);
    start = 1'b1;
    instruction = ins;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      @(negedge clk);
      start = poke && k == 1;
      instruction = $urandom;
      mem_ack = 1'b0;
      if (mem_req) begin
        req++;
        if (req == 1) begin a = mem_addr; we = mem_we; wd = mem_wdata; end
        else if ({mem_addr, mem_we, mem_wdata} !== {a, we, wd}) unstable++;
        if (req == wt) begin mem_ack = 1'b1; mem_rdata = rd; end
      end
      if (rf_we) begin we_n++; wa = rf_waddr; wdat = rf_wdata; end
      if (done) begin done_at = k; flt = fault; end
    end
    chk({name, ":latency"}, 128'(done_at), 128'(edone));
    chk({name, ":fault"}, 128'(flt), 128'(eflt));
    chk({name, ":req_cycles"}, 128'(req), 128'(ereq));
    chk({name, ":rf_we_pulses"}, 128'(we_n), 128'(ewe));
    if (ereq > 0) begin
      chk({name, ":mem_addr"}, 128'(a), 128'(ea));
      chk({name, ":mem_we"}, 128'(we), 128'(st));
      chk({name, ":req_stable"}, 128'(unstable), 128'(0));
      if (st) chk({name, ":mem_wdata"}, 128'(wd), 128'(rf[rt]));
    end
    if (ewe > 0) begin
      chk({name, ":rf_waddr"}, 128'(wa), 128'(rt));
      chk({name, ":rf_wdata"}, 128'(wdat), 128'(rd));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (busy || done || mem_req || rf_we || mem_we || mem_addr != 0 || mem_wdata != 0) bad++;
    end
    chk({name, ":idle_quiet"}, 128'(bad), 128'(0));
    chk({name, ":fault_hold"}, 128'(fault), 128'(eflt));
  endtask

  initial begin
    int found, bad;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;
    #3 reset = 1'b0;
    #1 chk("reset_outputs", 128'(outs()), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    rf[4] = 32'h0000_1000; rf[5] = 32'hDEAD_BEEF;
    run("store_zw", mk(OP_SW, 5'd4, 5'd5, 16'h0008), 1, 32'h0, 1'b0);
    rf[6] = 32'h0000_2000;
    run("load_w3", mk(OP_LW, 5'd6, 5'd7, 16'hFFFC), 4, 32'h1234_5678, 1'b0);
    rf[8] = 32'h0000_1001;
    run("misalign", mk(OP_LW, 5'd8, 5'd9, 16'h0000), 1, 32'h0, 1'b0);
    run("illegal", mk(6'b000000, 5'd4, 5'd5, 16'h0008), 1, 32'h0, 1'b0);
    run("timeout", mk(OP_SW, 5'd4, 5'd5, 16'h0008), 0, 32'h0, 1'b0);
    run("ack_last", mk(OP_LW, 5'd4, 5'd9, 16'h0008), TO, 32'hCAFE_F00D, 1'b0);
    run("load_r0", mk(OP_LW, 5'd4, 5'd0, 16'h0008), 2, 32'h5555_AAAA, 1'b0);
    run("busy_start", mk(OP_SW, 5'd4, 5'd5, 16'h0010), 2, 32'h0, 1'b1);

    found = 0;
    @(negedge clk);
    start = 1'b1;
    instruction = mk(OP_LW, 5'd4, 5'd9, 16'h0004);
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_req) found = 1;
    end
    chk("rst_mid_reached_mem", 128'(found), 128'(1));
    #2 reset = 1'b0;
    #1 chk("rst_mid_outputs", 128'(outs()), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (busy || done || rf_we || mem_req) bad++;
    end
    chk("stray_ack_ignored", 128'(bad), 128'(0));
    run("after_reset", mk(OP_LW, 5'd6, 5'd11, 16'h0010), 1, 32'h0BAD_F00D, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic [15:0] imm;
      int          wt;
      case ($urandom_range(0, 5))
        0, 1, 2: op = OP_LW;
        3, 4:    op = OP_SW;
        default: op = 6'($urandom);
      endcase
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      imm = 16'($urandom);
      rf[rt] = $urandom;
      rf[rs] = $urandom;
      if ($urandom_range(0, 5) != 0) begin
        rf[rs][1:0] = 2'b00;
        imm[1:0] = 2'b00;
      end
      case ($urandom_range(0, 7))
        0: wt = 1;
        1: wt = 2;
        2: wt = 3;
        3: wt = 5;
        4: wt = 14;
        5: wt = 15;
        6: wt = 16;
        default: wt = 0;
      endcase
      run("rand", mk(op, rs, rt, imm), wt, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
